// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types and width helpers for the FIFO write-port arbiter.
//            Holds the arbiter state encoding and the functions that size the
//            round-robin pointer and the beat counter from the parameters.
// Contents : arb_state_e  - IDLE / BURST
//            idx_width()  - bits needed to hold a requester index (>=1)
//            cnt_width()  - bits for the beat counter, clog2(MAX_BURST)+1
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 8;

  // A single requester still needs a 1-bit index so the pointer never
  // collapses to a zero-width vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit beyond clog2 keeps MAX_BURST=1 at a legal 1-bit width.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  localparam int DEF_PTR_W = idx_width(DEF_NUM_REQ);
  localparam int DEF_CNT_W = cnt_width(DEF_MAX_BURST);

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : Combinational round-robin selector. Picks the first set bit of
//            req_i searching upward from ptr_i+1 (modulo NUM_REQ).
// Ports    : req_i   [NUM_REQ-1:0] request vector
//            ptr_i   [PTR_W-1:0]   index of the most recently served requester
//            pick_o  [NUM_REQ-1:0] one-hot winner (zero when no request)
//            valid_o               any request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   start;
  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] pick_rot;
  logic               found;
  int                 src_idx;

  // Search starts one past the last-served requester, wrapping at the top.
  assign start = (ptr_i >= LAST_IDX) ? '0 : ptr_i + PTR_W'(1);

  always_comb begin
    req_rot  = '0;
    pick_rot = '0;
    pick_o   = '0;
    found    = 1'b0;
    src_idx  = 0;
    // Rotate so the highest-priority requester lands on bit 0.
    for (int j = 0; j < NUM_REQ; j++) begin
      src_idx = int'(start) + j;
      if (src_idx >= NUM_REQ) src_idx = src_idx - NUM_REQ;
      req_rot[j] = req_i[src_idx];
    end
    // Lowest set bit of the rotated vector wins.
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_rot[j]) begin
        pick_rot[j] = 1'b1;
        found       = 1'b1;
      end
    end
    // Rotate the one-hot result back into requester numbering.
    for (int j = 0; j < NUM_REQ; j++) begin
      src_idx = int'(start) + j;
      if (src_idx >= NUM_REQ) src_idx = src_idx - NUM_REQ;
      pick_o[src_idx] = pick_rot[j];
    end
  end

  assign valid_o = |req_i;

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            producers. A grant is held for a burst that ends on the
//            requester's last beat, after MAX_BURST beats, or when the
//            requester drops req. FIFO backpressure stalls the burst.
// Ports    : clk, rst           clock, synchronous active-high reset
//            req/req_last       per-requester valid and last-beat flags
//            req_data           packed data, requester i at [i*DW +: DW]
//            fifo_full          FIFO cannot accept a write
//            grant              registered one-hot grant (zero when idle)
//            accept             one-hot beat-taken pulse
//            fifo_wr_en/data    FIFO write side
//            busy               high while in BURST
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            accept,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy
);

  localparam int               PTR_W    = idx_width(NUM_REQ);
  localparam int               CNT_W    = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

  arb_state_e         state_q,    state_d;
  logic [NUM_REQ-1:0] grant_q,    grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q,   rr_ptr_d;

  logic [NUM_REQ-1:0]    pick;
  logic                  pick_valid;
  logic [PTR_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  req_g;
  logic                  last_g;
  logic                  beat;
  logic                  burst_end;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // AND-OR mux keyed by the one-hot grant; yields zero when nothing is granted.
  always_comb begin
    sel_data  = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data  = sel_data | data_arr[i];
        grant_idx = PTR_W'(i);
      end
    end
  end

  assign req_g  = |(req & grant_q);
  assign last_g = |(req_last & grant_q);

  // rst gates the beat so a write never issues on the reset edge.
  assign beat      = (state_q == BURST) && req_g && !fifo_full && !rst;
  assign burst_end = beat && (last_g || (beat_cnt_q == CNT_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= PTR_RST;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    fifo_wr_en = beat;
    accept     = beat ? grant_q : '0;
    fifo_data  = sel_data;
    busy       = (state_q == BURST);

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = BURST;
        end
      end
      BURST: begin
        // Dropping req releases the grant exactly like a completed burst.
        if (!req_g || burst_end) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = grant_idx;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    endcase
  end

  assign grant = grant_q;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed self-checking bench for fifo_wr_arbiter. Producer
//            queues drive req/req_last/req_data and pop on accept; expected
//            FIFO writes and grant order are queued when stimulus is loaded
//            and compared as the DUT writes / grants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic             fifo_full;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    accept;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data;
  logic             busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_last   (req_last),
    .req_data   (req_data),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .accept     (accept),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .busy       (busy)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [NR-1:0] gq[$];
  logic [DW:0]   pq[NR][$];   // {last, data} per producer
  logic [NR-1:0] acc;
  logic [NR-1:0] prev_grant = '0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (pq[i].size() > 0) begin
        req[i]               = 1'b1;
        req_last[i]          = pq[i][0][DW];
        req_data[i*DW +: DW] = pq[i][0][DW-1:0];
      end else begin
        req[i]               = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // One clock: capture accept mid-cycle, advance producers after the edge.
  task automatic step();
    @(negedge clk);
    acc = accept;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    drive();
  endtask

  task automatic load(input int i, input int n, input logic [DW-1:0] base, input int last_every);
    logic          lst;
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      lst = (last_every > 0) && (((k + 1) % last_every) == 0);
      d   = base + DW'(k);
      pq[i].push_back({lst, d});
    end
  endtask

  task automatic expect_words(input int i, input logic [DW-1:0] base, input int first, input int n);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      w.idx  = i;
      w.data = base + DW'(first + k);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    while (((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()) != 0 ||
            exp_q.size() != 0 || grant != '0) && cyc < budget) begin
      step();
      cyc++;
    end
    chk("done_in_budget", 32'(cyc < budget), 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("grants_drained", gq.size(), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) pq[i].delete();
    drive();
    step();
    step();
    rst = 1'b0;
  endtask

  // Write scoreboard, grant-order tracker and invariants, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    if (fifo_wr_en) begin
      chk("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_data", fifo_data, e.data);
        chk("wr_accept", accept, 32'(1) << e.idx);
      end
    end else begin
      chk("accept_without_write", accept, 0);
    end
    chk("wr_while_full", fifo_wr_en & fifo_full, 0);
    chk("accept_in_grant", accept & ~grant, 0);
    chk("grant_onehot", 32'($countones(grant) <= 1), 1);
    if (grant != '0 && prev_grant == '0) begin
      chk("grant_expected", 32'(gq.size() > 0), 1);
      if (gq.size() > 0) chk("grant_order", grant, gq.pop_front());
    end
    prev_grant = grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; req_last = '0; req_data = '0;
    do_reset();

    // Reset state
    chk("rst_grant", grant, 0);
    chk("rst_accept", accept, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_busy", busy, 0);

    // Single requester, 3 beats, last on the third
    load(1, 3, 8'hA0, 3);
    gq.push_back(4'b0010);
    expect_words(1, 8'hA0, 0, 3);
    drive();
    #1 chk("t1_grant_same_cycle", grant, 0);
    step();
    chk("t1_grant_latency", grant, 4'b0010);
    chk("t1_busy", busy, 1);
    chk("t1_wr_en", fifo_wr_en, 1);
    chk("t1_first_data", fifo_data, 8'hA0);
    wait_done(20);
    chk("t1_grant_released", grant, 0);
    chk("t1_idle", busy, 0);

    // Pointer now at 1: requester 2 must beat requester 0
    load(0, 2, 8'hB0, 2);
    load(2, 2, 8'hC0, 2);
    gq.push_back(4'b0100);
    gq.push_back(4'b0001);
    expect_words(2, 8'hC0, 0, 2);
    expect_words(0, 8'hB0, 0, 2);
    drive();
    wait_done(30);

    // All four requesting, 2-beat bursts, two rounds
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 4, 8'h20 + 8'(16 * i), 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin
        gq.push_back(4'(1 << i));
        expect_words(i, 8'h20 + 8'(16 * i), 2 * r, 2);
      end
    drive();
    wait_done(100);

    // Forced rotation, requester 2 alone: 8 beats then re-grant
    do_reset();
    load(2, 10, 8'hE0, 0);
    gq.push_back(4'b0100);
    gq.push_back(4'b0100);
    expect_words(2, 8'hE0, 0, 10);
    drive();
    wait_done(60);

    // Forced rotation with requester 0 pending: 0 served before 2 again
    do_reset();
    load(2, 9, 8'hF0, 0);
    drive();
    step();
    load(0, 1, 8'h5A, 1);
    drive();
    gq.push_back(4'b0100);
    gq.push_back(4'b0001);
    gq.push_back(4'b0100);
    expect_words(2, 8'hF0, 0, 8);
    expect_words(0, 8'h5A, 0, 1);
    expect_words(2, 8'hF0, 8, 1);
    wait_done(60);

    // Backpressure for 5 cycles mid-burst; counter must hold
    do_reset();
    load(1, 9, 8'h60, 0);
    gq.push_back(4'b0010);
    gq.push_back(4'b0010);
    expect_words(1, 8'h60, 0, 9);
    drive();
    step();
    step();
    step();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_wr_en", fifo_wr_en, 0);
      chk("stall_accept", accept, 0);
      chk("stall_grant", grant, 4'b0010);
      step();
    end
    fifo_full = 1'b0;
    wait_done(40);

    // Abandon: requester 3 drops after one beat
    do_reset();
    load(3, 3, 8'h70, 0);
    gq.push_back(4'b1000);
    gq.push_back(4'b0001);
    expect_words(3, 8'h70, 0, 1);
    expect_words(0, 8'h5B, 0, 1);
    drive();
    step();
    step();
    pq[3].delete();
    load(0, 1, 8'h5B, 1);
    drive();
    #1;
    chk("abandon_no_write", fifo_wr_en, 0);
    chk("abandon_grant_held", grant, 4'b1000);
    step();
    chk("abandon_released", grant, 0);
    step();
    chk("abandon_next_grant", grant, 4'b0001);
    wait_done(20);

    // Reset during the second beat
    do_reset();
    load(0, 4, 8'h80, 4);
    gq.push_back(4'b0001);
    expect_words(0, 8'h80, 0, 1);
    drive();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_beat_wr_en", fifo_wr_en, 0);
    chk("rst_beat_accept", accept, 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_grant", grant, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_data", fifo_data, 0);
    chk("post_rst_wr_en", fifo_wr_en, 0);
    pq[0].delete();
    load(0, 1, 8'h90, 1);
    load(2, 1, 8'hA9, 1);
    gq.push_back(4'b0001);
    gq.push_back(4'b0100);
    expect_words(0, 8'h90, 0, 1);
    expect_words(2, 8'hA9, 0, 1);
    drive();
    wait_done(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's FIFO between NUM_REQ requesters.
- Grants one requester at a time and holds the grant for a burst: until that requester flags its last beat or MAX_BURST beats have been written.
- Honours FIFO backpressure and drives the FIFO's write enable and data input.
- Sits between producer blocks and the FIFO write side, in the FIFO write-clock domain.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, data word width (matches FIFO DATA_WIDTH)
MAX_BURST, 8, maximum beats per grant before forced rotation (>=1)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-requester request; data valid while high
req_last  input  NUM_REQ  per-requester last-beat flag, qualified by req
req_data  input  NUM_REQ*DATA_WIDTH  packed data, requester i in bits [i*DATA_WIDTH +: DATA_WIDTH]
fifo_full  input  1  FIFO full flag; high = no write may be issued
grant  output  NUM_REQ  one-hot registered grant; all-zero when idle
accept  output  NUM_REQ  one-hot pulse: requester i's beat taken this cycle
fifo_wr_en  output  1  FIFO write enable
fifo_data  output  DATA_WIDTH  FIFO write data
busy  output  1  high in BURST state

Behaviour:
- Reset values: grant=0, accept=0, fifo_wr_en=0, fifo_data=0, busy=0, state=IDLE, beat_cnt=0, rr_ptr=NUM_REQ-1 (requester 0 wins first).
- IDLE state:
  - If any req is high, select the first requester with req high, searching upward from rr_ptr+1 modulo NUM_REQ.
  - Register its one-hot grant and go to BURST.
  - Arbitration latency is 1 cycle from req to grant.
  - With no req high, stay in IDLE with grant=0.
- BURST state, granted index g:
  - beat = req[g] & ~fifo_full.
  - fifo_wr_en = beat; accept[g] = beat; fifo_data = req_data[g] (0 when no grant).
  - These three outputs are combinational from the registered grant.
  - Each beat increments beat_cnt (width clog2(MAX_BURST)+1).
- Burst end (beat occurs with req_last[g]=1, or beat_cnt==MAX_BURST-1):
  - Next cycle: rr_ptr<=g, beat_cnt<=0, grant<=0, state<=IDLE.
  - There is 1 idle cycle between bursts; back-to-back bursts from one requester therefore cost 1 bubble.
- Abandon: req[g]=0 while in BURST releases the grant with the same update as burst end, even though no last beat was seen.
- fifo_full high in BURST:
  - No beat, no accept; grant and beat_cnt hold.
  - The stall lasts indefinitely; requesters must keep req and data stable.
- MAX_BURST=1: every beat ends the burst.
- Non-granted requesters never see accept. Their req, req_last and req_data are ignored.
- Simultaneous requests are resolved purely by rr_ptr rotation; no fixed priority after the first grant.
- rst asserted mid-burst: all state returns to reset values on that edge. A beat in the reset cycle is not issued (fifo_wr_en forced 0 while rst=1).
- Invariants: grant is one-hot or zero; accept is subset of grant; fifo_wr_en implies ~fifo_full; at most MAX_BURST beats per grant.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum {IDLE, BURST}
  - width helper constants (clog2 of NUM_REQ and MAX_BURST)
- One sub-module rr_priority_picker: combinational. Inputs are the req vector and rr_ptr; outputs are a one-hot pick and a valid flag (rotate, priority-encode, rotate back).
- FSM, counter and datapath mux live in fifo_wr_arbiter.

Test Plan:
- Single requester, 3 beats: req[1]=1, last on beat 3, fifo_full=0 -> grant=0010 one cycle after req; accept[1] and fifo_wr_en high 3 cycles; data D0..D2 written in order; grant=0 on next cycle; rr_ptr=1.
- All four requesting continuously, each burst 2 beats -> grant order 0001, 0010, 0100, 1000, 0001; exactly 2 writes per grant; 1 idle cycle between bursts.
- Forced rotation: req[2] held, never last, MAX_BURST=8 -> exactly 8 writes, grant drops, re-grant to 2 only if no other req is pending.
- Backpressure: mid-burst fifo_full=1 for 5 cycles -> fifo_wr_en=0 and accept=0 for those cycles; grant and beat_cnt held; burst resumes with the next data word, none lost or duplicated.
- Abandon: req[3] drops after 1 beat without last -> grant released next cycle; pending req[0] granted after one IDLE cycle.
- Reset mid-burst: rst=1 for 1 cycle during beat 2 -> no write that cycle; all outputs 0; after release, req[0] and req[2] both high -> requester 0 granted first.
